// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract engine: one full adder walks a WIDTH-bit word LSB first,
// with valid/ready handshakes on the operand and result sides.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
  logic             cout_r, ovf_r;
  logic             fa_s, fa_co;
  logic             accept, last_bit;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_co)
  );

  assign in_ready  = (state == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign last_bit  = (cnt == CNT_W'(WIDTH - 1));
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign sum       = res_sr;
  assign cout      = cout_r;
  assign overflow  = ovf_r;

  // New sum bit enters at the MSB so the word is aligned after WIDTH shifts.
  assign res_nxt = (res_sr >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last_bit)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      carry  <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sr   <= a;
            b_sr   <= sub ? ~b : b;
            carry  <= sub;
            cnt    <= '0;
            res_sr <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_nxt;
          carry  <= fa_co;
          cnt    <= cnt + CNT_W'(1);
          // Carry into the MSB is still in the carry register on this edge.
          if (last_bit) begin
            cout_r <= fa_co;
            ovf_r  <= carry ^ fa_co;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized self-checking bench for serial_adder_ctrl against a word-level arithmetic model.

module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, sub;
  logic [WIDTH-1:0] a, b, sum;
  logic             out_valid, out_ready, cout, overflow, busy;

  int n_vec = 0;
  int n_err = 0;
  int n_in  = 0;
  int n_out = 0;

  serial_adder_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Word-level reference: {overflow, cout, sum} from integer arithmetic and sign rules.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x, y, input logic s);
    int unsigned full;
    logic [WIDTH-1:0] r;
    logic c, v;
    if (s) full = int'(x) + int'((~y) & 8'hFF) + 1;
    else   full = int'(x) + int'(y);
    r = full[WIDTH-1:0];
    c = full[WIDTH];
    if (s) v = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    else   v = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    return {v, c, r};
  endfunction

  task automatic do_op(input logic [WIDTH-1:0] x, y, input logic s, input int stall,
                       input bit noise);
    logic [WIDTH+1:0] exp;
    logic [WIDTH-1:0] held;
    int cyc;
    exp = model(x, y, s);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; a = x; b = y; sub = s; out_ready = 1'b0;
    @(posedge clk);
    n_in++;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 4 * WIDTH) begin
      if (in_ready) check("in_ready_run", in_ready, 0);
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, WIDTH);
    held = sum;
    for (int i = 0; i < stall; i++) begin
      if (noise) in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (out_valid !== 1'b1 || sum !== held || in_ready !== 1'b0)
        check("stall_hold", {out_valid, in_ready, sum}, {2'b10, held});
    end
    in_valid = 1'b0;
    check("sum", sum, exp[WIDTH-1:0]);
    check("cout", cout, exp[WIDTH]);
    check("overflow", overflow, exp[WIDTH+1]);
    out_ready = 1'b1;
    @(posedge clk);
    n_out++;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_idle", {out_valid, busy, in_ready}, 3'b001);
  endtask

  initial begin
    logic [WIDTH+1:0] e;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", {out_valid, busy, in_ready, cout, overflow, sum}, '0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);

    do_op(8'h05, 8'h03, 1'b0, 0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    do_op(8'h7F, 8'h01, 1'b0, 0, 1'b0);
    do_op(8'h05, 8'h07, 1'b1, 0, 1'b0);
    do_op(8'h80, 8'h01, 1'b1, 0, 1'b0);
    e = model(8'h80, 8'h01, 1'b1);
    check("model_sub_ovf", e, {2'b11, 8'h7F});
    do_op(8'h3C, 8'hA5, 1'b0, 5, 1'b1);

    // Reset three bits into RUN: nothing from that operation may surface.
    @(negedge clk);
    in_valid = 1'b1; a = 8'hAA; b = 8'h55; sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst", {out_valid, busy, in_ready, cout, overflow, sum}, {3'b001, 10'h0});
    do_op(8'h10, 8'h20, 1'b0, 0, 1'b0);

    // Reset coinciding with an offered operand: reset wins.
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; a = 8'h11; b = 8'h22;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_vs_hs", {busy, out_valid}, 2'b00);

    for (int k = 0; k < 20; k++)
      do_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 4)), 1'b1);

    check("hs_count", n_in, n_out);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
